// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM encodings,
// frame geometry and the byte-acceptance decode.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 2;
    localparam int MAX_WORDS      = 128;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    // Only the in-frame states consume stream bytes.
    function automatic logic takes_bytes(input state_t s);
        return (s == S_HDR) || (s == S_LO) || (s == S_HI) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory: header, little-endian word
// pairs, then a modulo-256 checksum; pulses cpu_start when the image verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = MAX_WORDS,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8 * BYTES_PER_WORD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              i_we,
    output logic [ADDR_W-1:0] i_waddr,
    output logic [DATA_W-1:0] i_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_start
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [7:0]        lo_q;
    logic [7:0]        csum;
    logic              take;

    assign byte_ready = takes_bytes(state);
    assign take       = byte_valid & byte_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            last_idx  <= '0;
            lo_q      <= '0;
            csum      <= '0;
            i_we      <= 1'b0;
            i_waddr   <= '0;
            i_wdata   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_start <= 1'b0;
        end else begin
            i_we      <= 1'b0;
            cpu_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_req) begin
                        state <= S_HDR;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        error <= 1'b0;
                        idx   <= '0;
                        csum  <= '0;
                    end
                end
                S_HDR: begin
                    if (take) begin
                        if (byte_data == 8'd0 || int'(byte_data) > DEPTH) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            last_idx <= ADDR_W'(byte_data - 8'd1);
                            state    <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (take) begin
                        lo_q  <= byte_data;
                        csum  <= csum + byte_data;
                        state <= S_HI;
                    end
                end
                S_HI: begin
                    if (take) begin
                        // Write lands the cycle after the high byte; the next
                        // HI accept is at least two cycles away, so no overlap.
                        i_we    <= 1'b1;
                        i_waddr <= idx;
                        i_wdata <= DATA_W'({byte_data, lo_q});
                        csum    <= csum + byte_data;
                        if (idx == last_idx) begin
                            state <= S_CSUM;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_LO;
                        end
                    end
                end
                S_CSUM: begin
                    if (take) begin
                        busy <= 1'b0;
                        if (csum == byte_data) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_start <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
